sum_ram_drain: RTL
==================

SUM_RAM_DRAIN -- requirements
Module: sum_ram_drain

Interface
REQ-001 Parameter C_DSIZE, default 24: signed width of accumulated sums read from the sum RAM.
REQ-002 Parameter C_ASIZE, default 10: sum RAM address width.
REQ-003 Parameter C_OSIZE, default 8: signed output width.
REQ-004 Parameter C_SSIZE, default 5: shift-amount width.
REQ-005 Parameter C_RD_LAT, default 2: sum RAM read latency in cycles, from O_raddr to I_rdata0/1.
REQ-006 I_clk  in  1  single clock; all logic is on the rising edge.
REQ-007 I_rst  in  1  reset, synchronous and active-high.
REQ-008 I_start  in  1  one-cycle pulse that launches a drain.
REQ-009 I_bank_sel  in  1  bank select, latched at start: 0 reads I_rdata0, 1 reads I_rdata1.
REQ-010 I_len  in  C_ASIZE+1  word count, range 0..2^C_ASIZE, latched at start.
REQ-011 I_bias  in  C_DSIZE  signed bias, latched at start.
REQ-012 I_shift  in  C_SSIZE  right-shift amount, latched at start.
REQ-013 I_relu_en  in  1  ReLU enable, latched at start.
REQ-014 O_rden  out  1  read strobe for the sum RAM.
REQ-015 O_raddr  out  C_ASIZE  sum RAM read address.
REQ-016 I_rdata0, I_rdata1  in  C_DSIZE each  read data from sum RAM bank 0 and bank 1.
REQ-017 O_dout_valid  out  1  output data valid.
REQ-018 O_dout  out  C_OSIZE  output data.
REQ-019 I_dout_ready  in  1  downstream ready.
REQ-020 O_busy  out  1  high while a drain is in progress.
REQ-021 O_done  out  1  one-cycle pulse when a drain completes.

Function
REQ-022 FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE->RUN on I_start with I_len>0.
- IDLE->DONE on I_start with I_len=0.
- RUN->FLUSH after the last read is issued.
- FLUSH->DONE when nothing is in flight and the FIFO is empty.
- DONE->IDLE after one cycle.
REQ-023 O_busy shall be 1 in RUN, FLUSH and DONE, and 0 in IDLE.
REQ-024 O_done shall be 1 only in DONE.
REQ-025 I_start shall be ignored while O_busy=1.
REQ-026 Reads: O_raddr runs 0..I_len-1 in order, one address per O_rden cycle.
REQ-027 O_raddr shall hold its last value when O_rden=0.
REQ-028 O_rden may assert only when (in-flight reads + FIFO occupancy) < 4, so data is never dropped under backpressure.
REQ-029 Datapath, one register stage after data returns:
- sign-extend the sum and I_bias to C_DSIZE+1 bits and add them;
- if shift>0, add 2^(shift-1) (round half up);
- arithmetic right shift by shift;
- if I_relu_en, clamp negative values to 0;
- saturate to [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1].
REQ-030 If shift >= C_DSIZE+1, the pre-saturation result shall be 0 for a non-negative sum and -1 for a negative sum.
REQ-031 The output FIFO shall be 4 deep, first-word fall-through.
REQ-032 A word transfers when O_dout_valid and I_dout_ready are both 1.
REQ-033 O_dout shall stay stable while O_dout_valid=1 and I_dout_ready=0.
REQ-034 Latency with I_dout_ready held at 1:
- I_start is sampled in cycle 0;
- the first O_rden is in cycle 1;
- the first O_dout_valid is in cycle C_RD_LAT+2;
- throughput is 1 word per cycle.
REQ-035 O_done shall pulse in the cycle after the final output transfer.
REQ-036 With I_len=0, O_done shall pulse in cycle 1 with no reads and no outputs.
REQ-037 With I_len=2^C_ASIZE, the address shall end at 2^C_ASIZE-1 with no wrap and no extra read.

Reset
REQ-038 While I_rst=1, the block shall:
- go to IDLE;
- drive O_rden=0, O_raddr=0, O_dout_valid=0, O_dout=0, O_busy=0, O_done=0;
- empty the FIFO and clear the in-flight count.
REQ-039 A reset mid-drain shall abort the drain: no further outputs and no O_done.
REQ-040 Read data returning after reset shall be discarded.

Structure
REQ-041 The FSM state encoding and the FIFO depth constant (4) shall live in the shared package cnna_pkg.
REQ-042 The output FIFO shall be one sub-module, sync_fifo_fwft, parameterised by width and depth.
REQ-043 The read-issue logic and the arithmetic pipeline shall live in sum_ram_drain.

Verification
REQ-044 Basic drain:
- stimulus: I_len=4, bank 0 holds 100, -100, 1000, 5; bias=0, shift=2, relu=0, ready=1;
- required: outputs 25, -25, 127, 1; first valid at cycle 4; O_done once.
REQ-045 ReLU, bias and bank select:
- stimulus: bank 1 holds -8, 7; bias=1, shift=0, relu=1;
- required: outputs 0, 8; bank 0 data never selected.
REQ-046 Backpressure:
- stimulus: I_len=16, I_dout_ready toggled 1/0 randomly, stalls of 10 cycles;
- required: 16 ordered outputs, no loss or duplication, O_dout stable during stalls, reads never more than 4 ahead.
REQ-047 Boundaries:
- stimulus: I_len=0, then I_len=1024, then I_start pulsed while busy;
- required: done in cycle 1 with no reads; last O_raddr=1023; second start ignored.
REQ-048 Reset mid-drain:
- stimulus: I_rst high in cycle 6 of a 64-word drain, then a new start with I_len=2;
- required: all outputs 0 after reset, no O_done from the aborted drain, and the next drain is correct.

Source files
------------

// File: rtl/cnna_pkg.sv
// rtl/cnna_pkg.sv - shared FSM encoding and FIFO depth for the sum RAM drain
package cnna_pkg;

    // Drain sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Output FIFO depth; also the cap on reads issued but not yet consumed
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word fall-through FIFO
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, empties the FIFO
//   s_tvalid  write strobe (ignored when full)
//   s_tdata   write data
//   m_tvalid  head word present
//   m_tdata   head word, forced to 0 while empty
//   m_tready  consumer accepts the head word
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr;
    logic             rd;

    always_comb begin
        wr       = s_tvalid && (count < CW'(DEPTH));
        rd       = m_tready && (count != '0);
        m_tvalid = (count != '0);
        // Zero while empty so the output is clean out of reset
        m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/sum_ram_drain.sv
// rtl/sum_ram_drain.sv - drains accumulated sums from RAM through bias/round/shift/ReLU/saturate
//
// Ports:
//   I_clk, I_rst             clock and synchronous active-high reset
//   I_start                  launch pulse (ignored while O_busy)
//   I_bank_sel, I_len,       drain parameters, latched on I_start
//   I_bias, I_shift, I_relu_en
//   O_rden, O_raddr          sum RAM read strobe and address
//   I_rdata0, I_rdata1       sum RAM bank read data, C_RD_LAT cycles after the address
//   O_dout_valid, O_dout,    output stream
//   I_dout_ready
//   O_busy, O_done           drain in progress / one-cycle completion pulse
module sum_ram_drain
    import cnna_pkg::*;
#(
    parameter int C_DSIZE  = 24,
    parameter int C_ASIZE  = 10,
    parameter int C_OSIZE  = 8,
    parameter int C_SSIZE  = 5,
    parameter int C_RD_LAT = 2
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_start,
    input  logic                      I_bank_sel,
    input  logic [C_ASIZE:0]          I_len,
    input  logic signed [C_DSIZE-1:0] I_bias,
    input  logic [C_SSIZE-1:0]        I_shift,
    input  logic                      I_relu_en,
    output logic                      O_rden,
    output logic [C_ASIZE-1:0]        O_raddr,
    input  logic signed [C_DSIZE-1:0] I_rdata0,
    input  logic signed [C_DSIZE-1:0] I_rdata1,
    output logic                      O_dout_valid,
    output logic [C_OSIZE-1:0]        O_dout,
    input  logic                      I_dout_ready,
    output logic                      O_busy,
    output logic                      O_done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Two guard bits: one for the bias add, one for the rounding add
    localparam int WW = C_DSIZE + 2;
    localparam logic signed [WW-1:0] O_MAX = WW'((2 ** (C_OSIZE - 1)) - 1);
    localparam logic signed [WW-1:0] O_MIN = WW'(-(2 ** (C_OSIZE - 1)));

    drain_state_t              state;
    logic [C_ASIZE:0]          len_q;
    logic [C_ASIZE:0]          n_issued;
    logic                      bank_q;
    logic signed [C_DSIZE-1:0] bias_q;
    logic [C_SSIZE-1:0]        shift_q;
    logic                      relu_q;

    // Reads issued (including the one on O_rden now) whose word has not left the FIFO
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_after_pop;
    logic [C_RD_LAT-1:0]       vpipe;

    logic                      pop;
    logic                      room;
    logic                      issue;
    logic                      data_valid;
    logic signed [C_DSIZE-1:0] rdata_sel;
    logic signed [WW-1:0]      sum_w;
    logic signed [WW-1:0]      rnd_w;
    logic signed [WW-1:0]      pre_w;
    logic signed [WW-1:0]      res_w;
    logic [C_OSIZE-1:0]        out_word;

    // Read issue control
    always_comb begin
        pop           = O_dout_valid & I_dout_ready;
        cnt_after_pop = cnt - CW'(pop);
        room          = cnt_after_pop < CW'(FIFO_DEPTH);
        issue         = ((state == ST_IDLE) && I_start && (I_len != '0))
                      || ((state == ST_RUN) && (n_issued != len_q) && room);
        data_valid    = vpipe[C_RD_LAT-1];
    end

    // Arithmetic: bias, round half up, arithmetic shift, ReLU, saturate.
    // The result is registered by the FIFO write, which is the single
    // pipeline stage after the RAM data returns.
    always_comb begin
        rdata_sel = bank_q ? I_rdata1 : I_rdata0;
        sum_w     = WW'(rdata_sel) + WW'(bias_q);
        rnd_w     = '0;
        pre_w     = sum_w;
        if (int'(shift_q) >= C_DSIZE + 1) begin
            res_w = sum_w[WW-1] ? '1 : '0;
        end else if (shift_q != '0) begin
            rnd_w = WW'(1) << (shift_q - 1'b1);
            pre_w = sum_w + rnd_w;
            res_w = pre_w >>> shift_q;
        end else begin
            res_w = sum_w;
        end
        if (relu_q && res_w[WW-1]) begin
            res_w = '0;
        end
        if (res_w > O_MAX) begin
            out_word = O_MAX[C_OSIZE-1:0];
        end else if (res_w < O_MIN) begin
            out_word = O_MIN[C_OSIZE-1:0];
        end else begin
            out_word = res_w[C_OSIZE-1:0];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_IDLE;
            O_rden   <= 1'b0;
            O_raddr  <= '0;
            O_busy   <= 1'b0;
            O_done   <= 1'b0;
            cnt      <= '0;
            vpipe    <= '0;
            n_issued <= '0;
            len_q    <= '0;
            bank_q   <= 1'b0;
            bias_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else begin
            // Tracks which RAM return slots carry data we asked for
            vpipe  <= (vpipe << 1) | C_RD_LAT'(O_rden);
            cnt    <= cnt_after_pop + CW'(issue);
            O_rden <= issue;

            case (state)
                ST_IDLE: begin
                    if (I_start) begin
                        len_q   <= I_len;
                        bank_q  <= I_bank_sel;
                        bias_q  <= I_bias;
                        shift_q <= I_shift;
                        relu_q  <= I_relu_en;
                        O_busy  <= 1'b1;
                        if (I_len == '0) begin
                            state  <= ST_DONE;
                            O_done <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            O_raddr  <= '0;
                            n_issued <= (C_ASIZE + 1)'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (n_issued == len_q) begin
                        state <= ST_FLUSH;
                    end else if (room) begin
                        // O_raddr holds the last address issued
                        O_raddr  <= O_raddr + 1'b1;
                        n_issued <= n_issued + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_after_pop == '0) begin
                        state  <= ST_DONE;
                        O_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                    O_done <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    O_busy <= 1'b0;
                    O_done <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH (C_OSIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (I_clk),
        .rst      (I_rst),
        .s_tvalid (data_valid),
        .s_tdata  (out_word),
        .m_tvalid (O_dout_valid),
        .m_tdata  (O_dout),
        .m_tready (I_dout_ready)
    );

endmodule
